// File: rtl/uart_pkg.sv
// Shared UART types: counter/shift control points, tx FSM states and the
// control-point bundle, parity encodings, and a counter-width helper.
package uart_pkg;

    typedef enum logic [1:0] {CLR, INC, NO} cnt_ctl_e;
    typedef enum logic [1:0] {LOAD, SHIFT, NONE} shf_ctl_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    typedef struct packed {
        cnt_ctl_e clk_ctl;
        cnt_ctl_e smp_ctl;
        cnt_ctl_e bit_ctl;
        shf_ctl_e shf_ctl;
        logic     done;
    } tx_cp_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Transmit sequencer: state register plus next-state and control-point logic.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int PARITY = PAR_NONE
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      accept_i,
    input  logic      tick_i,
    input  logic      full_bit_i,
    input  logic      bit_last_i,
    output tx_state_e state_o,
    output tx_state_e state_d_o,
    output tx_cp_t    cp_o
);

    tx_state_e state_q, state_d;
    tx_cp_t    cp;

    // Next state and control points; counters clear on every state change.
    always_comb begin
        state_d    = state_q;
        cp.clk_ctl = INC;
        cp.smp_ctl = tick_i ? INC : NO;
        cp.bit_ctl = NO;
        cp.shf_ctl = NONE;
        cp.done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cp.bit_ctl = CLR;
                if (accept_i) begin
                    state_d    = S_START;
                    cp.shf_ctl = LOAD;
                end
            end
            S_START: if (full_bit_i) begin
                state_d    = S_DATA;
                cp.bit_ctl = CLR;
            end
            S_DATA: if (full_bit_i) begin
                cp.shf_ctl = SHIFT;
                cp.bit_ctl = INC;
                if (bit_last_i)
                    state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (full_bit_i) state_d = S_STOP;
            S_STOP: if (full_bit_i) begin
                state_d = S_IDLE;
                cp.done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q || state_q == S_IDLE) begin
            cp.clk_ctl = CLR;
            cp.smp_ctl = CLR;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    assign state_o   = state_q;
    assign state_d_o = state_d;
    assign cp_o      = cp;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter datapath: bit-timing counters, shift register, parity,
// and registered line/handshake outputs driven from the FSM's next state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 27,
    parameter int SAMPLES_PER_BIT = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = PAR_NONE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CLK_W = cnt_w(CLKS_PER_SAMPLE);
    localparam int SMP_W = cnt_w(SAMPLES_PER_BIT);
    localparam int BIT_W = cnt_w(DATA_BITS);
    localparam logic [CLK_W-1:0] CLK_MAX = CLK_W'(CLKS_PER_SAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_MAX = SMP_W'(SAMPLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);

    logic [CLK_W-1:0]     clk_q, clk_d;
    logic [SMP_W-1:0]     smp_q, smp_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d, rdy_q, busy_q, done_q;
    logic                 tick, full_bit, bit_last, accept;
    tx_state_e            state, state_d;
    tx_cp_t               cp;

    assign tick     = (clk_q == CLK_MAX);
    assign full_bit = tick && (smp_q == SMP_MAX);
    assign bit_last = (bit_q == BIT_MAX);
    // Gating by the registered ready keeps the edge that releases reset
    // or finishes a frame from also accepting.
    assign accept   = tx_valid && rdy_q;

    uart_tx_fsm #(.PARITY(PARITY)) u_fsm (
        .clk_i      (clock),
        .rst_ni     (reset),
        .accept_i   (accept),
        .tick_i     (tick),
        .full_bit_i (full_bit),
        .bit_last_i (bit_last),
        .state_o    (state),
        .state_d_o  (state_d),
        .cp_o       (cp)
    );

    // Counter, shift-register and parity next values from the control points.
    always_comb begin
        clk_d   = clk_q;
        smp_d   = smp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (cp.clk_ctl)
            CLR:     clk_d = '0;
            INC:     clk_d = tick ? '0 : clk_q + CLK_W'(1);
            default: ;
        endcase
        case (cp.smp_ctl)
            CLR:     smp_d = '0;
            INC:     smp_d = (smp_q == SMP_MAX) ? '0 : smp_q + SMP_W'(1);
            default: ;
        endcase
        case (cp.bit_ctl)
            CLR:     bit_d = '0;
            INC:     bit_d = bit_last ? '0 : bit_q + BIT_W'(1);
            default: ;
        endcase
        case (cp.shf_ctl)
            LOAD: begin
                shift_d = tx_data;
                par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
            end
            SHIFT:   shift_d = shift_q >> 1;
            default: ;
        endcase
    end

    // Line level for the state being entered, so tx changes on the same edge.
    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // Datapath and output registers; reset abandons any frame with the line high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_q   <= '0;
            smp_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            clk_q   <= clk_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rdy_q   <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= cp.done;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = rdy_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

    logic unused_state;
    assign unused_state = ^state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no/even/odd parity) at
// BIT_CLKS=8, frames checked bit-by-bit against hand-built expectations.
module tb_uart_tx;

    localparam int BIT = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic [2:0] tx_valid;
    logic [2:0] tx_ready, tx, tx_busy, tx_done;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clock = ~clock;

    uart_tx #(.CLKS_PER_SAMPLE(2), .SAMPLES_PER_BIT(4), .DATA_BITS(8), .PARITY(0)) u0 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx #(.CLKS_PER_SAMPLE(2), .SAMPLES_PER_BIT(4), .DATA_BITS(8), .PARITY(1)) u1 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx #(.CLKS_PER_SAMPLE(2), .SAMPLES_PER_BIT(4), .DATA_BITS(8), .PARITY(2)) u2 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx(tx[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    // Expected line level for frame bit b of instance par (0 none, 1 even, 2 odd).
    function automatic logic fbit(input int par, input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && par == 1) return ^d;
        if (b == 9 && par == 2) return ~^d;
        return 1'b1;
    endfunction

    // One frame on instance idx; optionally pokes a different request mid-frame.
    task automatic send(input int idx, input logic [7:0] d, input bit poke);
        int nb;
        nb = (idx == 0) ? 10 : 11;
        @(negedge clock);
        tx_data = d;
        tx_valid[idx] = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= nb*BIT + 1; k++) begin
            @(negedge clock);
            if (k < nb*BIT) begin
                chk($sformatf("tx%0d d%02h k%0d", idx, d, k), tx[idx], fbit(idx, d, k/BIT));
                chk($sformatf("rdy%0d k%0d", idx, k), tx_ready[idx], 1'b0);
                if (k == 0) chk("busy_on", tx_busy[idx], 1'b1);
            end else if (k == nb*BIT) begin
                chk("done_pulse", tx_done[idx], 1'b1);
                chk("rdy_end", tx_ready[idx], 1'b1);
                chk("busy_end", tx_busy[idx], 1'b0);
                chk("tx_idle", tx[idx], 1'b1);
            end else begin
                chk("done_clear", tx_done[idx], 1'b0);
            end
            if (k == 0) begin
                tx_valid[idx] = 1'b0;
                tx_data = ~d;
            end
            if (poke && k == 20) begin
                tx_data = d ^ 8'h3C;
                tx_valid[idx] = 1'b1;
            end
            if (k == 21) tx_valid[idx] = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b0;
        tx_data = '0;
        tx_valid = '0;
        repeat (3) @(negedge clock);
        chk("rst_tx", tx[0], 1'b1);
        chk("rst_rdy", tx_ready[0], 1'b0);
        chk("rst_busy", tx_busy[0], 1'b0);
        chk("rst_done", tx_done[0], 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("rel_rdy", tx_ready, 3'b111);

        send(0, 8'hA5, 1'b0);
        send(1, 8'h07, 1'b0);
        send(2, 8'h07, 1'b0);
        send(0, 8'h5A, 1'b1);

        // Back-to-back with tx_valid held: 0x00 then 0xFF on instance 0.
        @(negedge clock);
        tx_data = 8'h00;
        tx_valid[0] = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 2*(10*BIT + 1) - 1; k++) begin
            int j;
            logic [7:0] de;
            j  = (k < 10*BIT + 1) ? k : k - (10*BIT + 1);
            de = (k < 10*BIT + 1) ? 8'h00 : 8'hFF;
            @(negedge clock);
            if (j < 10*BIT) begin
                chk($sformatf("b2b d%02h j%0d", de, j), tx[0], fbit(0, de, j/BIT));
                chk($sformatf("b2b rdy j%0d", j), tx_ready[0], 1'b0);
            end else begin
                chk($sformatf("b2b done d%02h", de), tx_done[0], 1'b1);
                chk("b2b rdy_end", tx_ready[0], 1'b1);
            end
            if (k == 0) tx_data = 8'hFF;
            if (k == 10*BIT + 1) tx_valid[0] = 1'b0;
        end
        @(negedge clock);
        chk("b2b done_clear", tx_done[0], 1'b0);

        // Reset during data bit 3 (frame bit 4, cycles 32..39) of 0x00.
        @(negedge clock);
        tx_data = 8'h00;
        tx_valid[0] = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 34; k++) begin
            @(negedge clock);
            if (k == 0) tx_valid[0] = 1'b0;
        end
        chk("pre_rst_tx", tx[0], 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_tx", tx[0], 1'b1);
        chk("mid_rst_rdy", tx_ready[0], 1'b0);
        chk("mid_rst_busy", tx_busy[0], 1'b0);
        @(negedge clock);
        chk("mid_rst_tx2", tx[0], 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_rdy", tx_ready[0], 1'b1);
        send(0, 8'h3C, 1'b0);

        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom_range(0, 255));
            send(r % 3, d, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter that pairs with the existing UART receiver and uses the same bit timing. It runs from one system clock and sends 8N1 frames by default: a start bit (0), DATA_BITS data bits sent LSB first, an optional parity bit, and a stop bit (1). The bit period comes from the same clock-tick / oversample-count structure the receiver uses, so a loopback of `tx` to `rx` at equal parameters is error-free. Frames are accepted one at a time through a valid/ready handshake.

## Interface
- CLKS_PER_SAMPLE, default 27: clock cycles per oversample tick; ≥1.
- SAMPLES_PER_BIT, default 16: ticks per bit; ≥2.
- DATA_BITS, default 8: payload width; 5..9.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd.
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset; it is asserted when 0 and sampled only on the clock edge.
- tx_data  input  DATA_BITS  payload; sampled only on accept.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  block can accept; accept = tx_valid && tx_ready at a posedge.
- tx  output  1  serial line; idles at 1.
- tx_busy  output  1  a frame is in flight, from the START state through the STOP state.
- tx_done  output  1  one-cycle pulse when the stop bit completes.

## Operation
- BIT_CLKS = CLKS_PER_SAMPLE*SAMPLES_PER_BIT.
- Clock counter: counts 0..CLKS_PER_SAMPLE-1. A sample tick fires when it wraps.
- Sample counter: counts ticks 0..SAMPLES_PER_BIT-1. A full_bit fires on the tick where the sample count is SAMPLES_PER_BIT-1.
- Bit counter: counts 0..DATA_BITS-1.
- Both the clock and sample counters clear on every state change.
- State machine:
  - IDLE: tx=1, tx_ready=1. On accept, load tx_data into the shift register, compute parity, clear counters, go to START.
  - START: tx=0. On full_bit, go to DATA with bit count 0.
  - DATA: tx = shift[0]. On full_bit, shift right and increment the bit count. When bit count = DATA_BITS-1 and full_bit fires, go to PARITY if PARITY≠0, otherwise go to STOP.
  - PARITY: tx = parity bit. Even parity: XOR of data. Odd parity: XNOR of data. On full_bit, go to STOP.
  - STOP: tx=1. On full_bit, go to IDLE and pulse tx_done.
  - Unreachable encodings go to IDLE with tx=1.
- tx_valid and tx_data are ignored whenever tx_ready=0. A payload change mid-frame has no effect.
- Reset, including mid-frame: state goes to IDLE and all counters clear. Output values while reset=0: tx=1, tx_ready=0, tx_busy=0, tx_done=0. A partially sent frame is abandoned; the line returns high with no glitch low.

## Timing
- All outputs are registered, so there is no combinational path from input to output.
- First clock edge with reset=1: tx_ready goes to 1.
- Accept at edge E: tx=0, tx_busy=1 and tx_ready=0 from E.
  - Each bit holds for exactly BIT_CLKS cycles.
  - The stop bit ends at edge E + NBITS*BIT_CLKS, where NBITS = DATA_BITS + 2 + (PARITY≠0).
  - At that edge: tx_done=1 for one cycle, tx_ready=1, tx_busy=0.
- Back-to-back: if tx_valid is held high, the next accept happens on the edge after tx_done. The line stays high for BIT_CLKS+1 cycles between frames.
- Counter widths: $clog2 of each maximum count, minimum 1. No overflow is possible because all counters clear on wrap.

## Structure
- The shared `uart_pkg` holds:
  - the controlPoints-style counter-control enum (CLR / INC / NO) and the shift-control enum (LOAD / SHIFT / NONE);
  - the tx control-point struct;
  - the parity encoding constants.
- The receiver uses the same package.
- Split the design into:
  - `uart_tx_fsm`: state register plus combinational next-state and control-point logic;
  - `uart_tx`: datapath (counters, shift register, parity, output registers) and instantiation of `uart_tx_fsm`.

## Test plan
- Bench parameters: CLKS_PER_SAMPLE=2, SAMPLES_PER_BIT=4, giving BIT_CLKS=8.
- Send 0xA5, PARITY=0 -> tx shows 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles. tx_done occurs 80 cycles after accept; tx_ready stays 0 throughout the frame.
- Send 0x07 with PARITY=1, then with PARITY=2 -> parity bit is 1 for even and 0 for odd. The frame is 88 cycles.
- Hold tx_valid with 0x00 then 0xFF -> second accept on the edge after the first tx_done. The idle gap is 9 cycles and both frames decode correctly.
- Pulse tx_valid while tx_busy=1 with a different tx_data -> the request is ignored and the in-flight frame is unchanged.
- Drive reset=0 during data bit 3 -> tx=1 on the next edge and tx_ready=0 during reset. After release, tx_ready=1 one edge later, and a new frame 0x3C transmits correctly.
- Loopback tx into the existing receiver at equal parameters, with 256 random bytes -> every byte is received with rx_valid and no framing errors.
